// File: rtl/dcache_seq_if.sv
// dcache_seq_if: nibble-serial memory bus; dcache_seq is the master, external memory the slave.
interface dcache_seq_if #(parameter int AW = 20) ();
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic          strobe;
   logic          err;
   modport master (output req, we, addr, err, input strobe);
   modport slave  (input req, we, addr, err, output strobe);
endinterface

// File: rtl/dcache_seq.sv
// dcache_seq: miss sequencer pacing cache nibble strobes with the memory bus.
// Defining DCACHE_SEQ_FLUSH_EN builds the write-back/invalidate sweep engine.
module dcache_seq #(
   parameter int PA          = 22,
   parameter int LINE_LENGTH = 4,
   parameter int NLINES      = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_cpu_req,
   input  logic [PA-2:0]                     i_cpu_addr,
   input  logic                              i_cpu_fault,
   output logic                              o_cpu_ready,
   input  logic                              i_c_hit,
   input  logic                              i_c_push,
   input  logic                              i_c_pull,
   input  logic [PA-$clog2(LINE_LENGTH)-1:0] i_c_tag,
   output logic [PA-2:0]                     o_c_paddr,
   output logic                              o_c_flush_write,
   output logic                              o_c_fault,
   output logic                              o_c_rstrobe,
   output logic                              o_c_wstrobe,
   dcache_seq_if.master                      mem,
   input  logic                              i_flush_req,
   output logic                              o_flush_busy
);
   localparam int LW = $clog2(LINE_LENGTH);
   localparam int TW = PA - LW;
   localparam int CW = $clog2(2 * LINE_LENGTH);
   localparam int IW = $clog2(NLINES);
   localparam logic [2:0] IDLE = 3'd0, PUSH = 3'd1, PULL = 3'd2, SCAN = 3'd3, SPUSH = 3'd4;
   logic [2:0]    r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_addr;
   logic          r_we, r_err;
   logic          w_xfer, w_stb, w_last, w_gap, w_miss, w_flush;
   assign w_xfer = r_state inside {PUSH, PULL, SPUSH};
   assign w_stb  = w_xfer && mem.strobe;
   assign w_last = w_stb && r_cnt == CW'(2 * LINE_LENGTH - 1);
   // the cache drops its nibble offset on any strobe-less cycle, so a mid-line gap voids the line
   assign w_gap  = w_xfer && !mem.strobe && r_cnt != '0;
   assign w_miss = i_cpu_req && !i_cpu_fault && !i_c_hit;
`ifdef DCACHE_SEQ_FLUSH_EN
   logic [IW-1:0] r_idx;
   logic          w_scan_done;
   assign w_scan_done  = r_idx == IW'(NLINES - 1);
   assign w_flush      = !i_cpu_req && i_flush_req;
   assign o_flush_busy = r_state == SCAN || r_state == SPUSH;
   assign o_c_paddr    = o_flush_busy ? ((PA-1)'(r_idx) << (LW - 1)) : i_cpu_addr;
   always_ff @(posedge clk)
      if (reset) r_idx <= '0;
      else if (r_state == SCAN && !i_c_push) r_idx <= w_scan_done ? '0 : r_idx + IW'(1);
`else
   wire w_unused = i_flush_req | (SCAN == 3'(IW));
   assign w_flush      = 1'b0;
   assign o_flush_busy = 1'b0;
   assign o_c_paddr    = i_cpu_addr;
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       w_next = w_miss && i_c_push ? PUSH : w_miss && i_c_pull ? PULL : w_flush ? SCAN : IDLE;
         PUSH, PULL: w_next = w_last || w_gap ? IDLE : r_state;
`ifdef DCACHE_SEQ_FLUSH_EN
         SCAN:       w_next = i_c_push ? SPUSH : w_scan_done ? IDLE : SCAN;
         // a failed sweep write-back retries the same line from SCAN
         SPUSH:      w_next = w_last || w_gap ? SCAN : SPUSH;
`endif
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_gap ? '0 : r_cnt + CW'(w_stb);
         r_err   <= w_gap;
         if (!w_xfer && w_next inside {PUSH, PULL, SPUSH}) begin
            r_addr <= i_c_tag;
            r_we   <= w_next != PULL;
         end
      end
   assign o_cpu_ready     = r_state == IDLE && i_cpu_req && (i_cpu_fault || i_c_hit);
   assign o_c_rstrobe     = w_stb && r_state != PULL;
   assign o_c_wstrobe     = w_stb && r_state == PULL;
   assign o_c_flush_write = o_flush_busy;
   assign o_c_fault       = i_cpu_fault && !o_flush_busy;
   assign mem.req         = w_xfer;
   assign mem.we          = r_we;
   assign mem.addr        = r_addr;
   assign mem.err         = r_err;
endmodule

// File: doc/dcache_seq.md
# dcache_seq

Line-transfer sequencer for the data cache. Sits between the CPU load/store port, the data cache and the external nibble-serial memory bus. On a miss it decides between write-back (push) and fill (pull), drives the cache's per-nibble strobes in lock-step with the memory bus and releases the CPU when the access completes. An optional sweep engine writes back and invalidates every line on request.

## Interface

**Parameters**
- `PA`, 22: physical address width (halfword address `[PA-1:1]`).
- `LINE_LENGTH`, 4: bytes per line; `2*LINE_LENGTH` nibbles per transfer.
- `NLINES`, 4: lines in the cache; sets the sweep index width.

**Ports**
- Clocking: reset is `reset`, synchronous, active-high; the clock is `clk`.
- `cpu_req`, in, 1: load or store request valid; held until `cpu_ready`.
- `cpu_addr`, in, `PA-1`: request address.
- `cpu_fault`, in, 1: MMU fault on the current request.
- `cpu_ready`, out, 1: request complete this cycle.
- `c_hit` / `c_push` / `c_pull`, in, 1 each: cache status for `c_paddr`.
- `c_tag`, in, `PA-log2(LINE_LENGTH)`: line address from the cache.
- `c_paddr`, out, `PA-1`: address to cache (CPU or sweep).
- `c_flush_write`, out, 1: sweep write-back mode.
- `c_fault`, out, 1: fault forwarded to the cache (0 during sweep).
- `c_rstrobe`, out, 1: nibble leaving the cache (push).
- `c_wstrobe`, out, 1: nibble entering the cache (pull).
- `mem_req`, out, 1: bus request.
- `mem_we`, out, 1: 1 for push, 0 for pull.
- `mem_addr`, out, `PA-log2(LINE_LENGTH)`: line address.
- `mem_strobe`, in, 1: one nibble transferred this cycle.
- `mem_err`, out, 1: one-cycle pulse on a protocol error.
- `flush_req`, in, 1: start the sweep.
- `flush_busy`, out, 1: sweep in progress.

## Operation

**States:** IDLE, PUSH, PULL, SCAN, SPUSH.

**IDLE**
- `cpu_req && cpu_fault`: `cpu_ready`=1, no bus activity.
- `cpu_req && c_hit`: `cpu_ready`=1 combinationally.
- `c_push`: go to PUSH. `mem_addr` and `mem_we`=1 are latched from `c_tag`.
- `c_pull`: go to PULL. `mem_addr` is latched, `mem_we`=0.
- `flush_req` is taken only in IDLE with no `cpu_req`, and goes to SCAN. CPU requests win on the same cycle.

**PUSH / PULL**
- `mem_req`=1.
- Each `mem_strobe` cycle drives `c_rstrobe` (PUSH) or `c_wstrobe` (PULL) combinationally from `mem_strobe`.
- A 3-bit counter (width `log2(2*LINE_LENGTH)`) counts strobes.
- On strobe 8 (count 7): return to IDLE and clear `mem_req` the next cycle.
- IDLE then re-evaluates. After a push the cache reports pull. After a pull it reports hit, which gives `cpu_ready`.

**Strobe continuity**
- The cache resets its internal nibble offset on any cycle with no strobe. Once the first strobe arrives, the 8 strobes must be consecutive.
- A gap after 1–7 strobes: pulse `mem_err`, drop `mem_req`, go to IDLE.
- The cache therefore never sets valid or changes tag on that line; the request retries from IDLE.

**SCAN / SPUSH (sweep)**
- A sweep index `i` runs 0..`NLINES-1`.
- `c_paddr` = `{0, i, 0}`, `c_flush_write`=1.
- SCAN: if `c_push`, go to SPUSH (a bus transfer like PUSH). Otherwise increment `i`.
- After SPUSH completes, return to SCAN with the same `i`. The line is now clean and invalid, so the scan advances.
- After index `NLINES-1`, go to IDLE and clear `flush_busy`. `cpu_ready` is held 0 throughout the sweep.

**Reset**
- Outputs: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_err`=0, `flush_busy`=0, `cpu_ready`=0.
- Both strobes 0; counter and index 0; state IDLE.
- Reset asserted mid-transfer aborts at the next edge, with no `mem_err`.

## Timing

- Hit: 0-cycle latency (`cpu_ready` in the same cycle as `cpu_req`).
- Clean miss: 1 IDLE cycle + bus wait + 8 strobe cycles + 1 IDLE cycle for the hit.
- Dirty miss: push sequence, then the pull sequence.
- `mem_req` rises the cycle after the IDLE decision.
- `mem_strobe` is ignored when `mem_req`=0, and in IDLE.

## Configuration

- `DCACHE_SEQ_FLUSH_EN` defined: SCAN/SPUSH states and `flush_req` handling are built.
- Not defined:
  - `flush_req` is ignored.
  - `flush_busy` and `c_flush_write` are tied 0.
  - `c_paddr` = `cpu_addr` always.

## Test plan

- Hit load at 0x0040 with `c_hit`=1 → `cpu_ready` the same cycle; `mem_req` stays 0.
- Clean miss, memory strobing 8 consecutive cycles after 2 wait cycles → 8 `c_wstrobe` pulses, `mem_we`=0, `mem_addr`=`c_tag`, `cpu_ready` on the following hit cycle.
- Dirty miss → PUSH with 8 `c_rstrobe` and `mem_we`=1, then PULL of the new tag, then `cpu_ready`.
- Gap after the 5th strobe → `mem_err` pulse, `mem_req` low the next cycle, retry completes the fill.
- Reset at strobe 3 of a PULL → all outputs at their reset values the next cycle; no `mem_err`.
- With the macro, `NLINES`=4, lines 1 and 3 dirty → exactly 2 SPUSH transfers at those indices; `flush_busy` drops after index 3; a `cpu_req` arriving during the sweep completes after it.
